// File: rtl/a51_keystream_gen.sv
// A5/1 keystream core.
// Three LFSRs (19/22/23 bits) absorb a session key and a frame number with
// regular clocking, run a majority-clocked mixing phase, then stream one
// keystream bit per valid/ready handshake. Register contents stay visible on
// the debug outputs after a run completes, until the next start.
module a51_keystream_gen #(
  parameter int unsigned KEY_BITS   = 64,
  parameter int unsigned FRAME_BITS = 22,
  parameter int unsigned MIX_CYCLES = 100,
  parameter int unsigned KS_BITS    = 228
) (
  input  logic                  clock,
  input  logic                  reset,     // asynchronous, active-low
  input  logic [KEY_BITS-1:0]   key,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  start,
  input  logic                  ks_ready,
  output logic                  ks_valid,
  output logic                  ks_bit,
  output logic                  busy,
  output logic                  done,
  output logic [18:0]           out19,
  output logic [21:0]           out22,
  output logic [22:0]           out23
);

  // The counter serves every phase, so it must hold the largest phase length.
  localparam int unsigned CNT_MAX_A = (KEY_BITS > MIX_CYCLES + 1) ? KEY_BITS : MIX_CYCLES + 1;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > KS_BITS) ? CNT_MAX_A : KS_BITS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX) + 1;
  localparam int unsigned KEY_IDX_W   = (KEY_BITS   > 1) ? $clog2(KEY_BITS)   : 1;
  localparam int unsigned FRAME_IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_FRAME,
    S_MIX,
    S_STREAM
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [18:0]      r_r1;
  logic [21:0]      r_r2;
  logic [22:0]      r_r3;
  logic             r_ks_valid;
  logic             r_busy;
  logic             r_done;

  logic        w_key_bit;
  logic        w_frame_bit;
  logic        w_in_bit;
  logic        w_r1_fb;
  logic        w_r2_fb;
  logic        w_r3_fb;
  logic        w_c1;
  logic        w_c2;
  logic        w_c3;
  logic        w_maj;
  logic [18:0] w_r1_reg;
  logic [21:0] w_r2_reg;
  logic [22:0] w_r3_reg;
  logic [18:0] w_r1_maj;
  logic [21:0] w_r2_maj;
  logic [22:0] w_r3_maj;
  logic        w_handshake;
  logic        w_last_bit;

  // Key and frame are read bit-serially, indexed by the phase counter.
  assign w_key_bit   = key[r_cnt[KEY_IDX_W-1:0]];
  assign w_frame_bit = frame[r_cnt[FRAME_IDX_W-1:0]];

  // Select the bit being absorbed during the regular-clock load phases.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_in_bit unassigned,
    // which would otherwise infer a latch.
    w_in_bit = 1'b0;
    if (r_state == S_LOAD_KEY) begin
      w_in_bit = w_key_bit;
    end else if (r_state == S_LOAD_FRAME) begin
      w_in_bit = w_frame_bit;
    end
  end

  // Feedback taps of each register.
  assign w_r1_fb = r_r1[13] ^ r_r1[16] ^ r_r1[17] ^ r_r1[18];
  assign w_r2_fb = r_r2[20] ^ r_r2[21];
  assign w_r3_fb = r_r3[7]  ^ r_r3[20] ^ r_r3[21] ^ r_r3[22];

  // Regular clock: every register shifts toward the MSB, mixing in the input bit.
  assign w_r1_reg = {r_r1[17:0], w_r1_fb ^ w_in_bit};
  assign w_r2_reg = {r_r2[20:0], w_r2_fb ^ w_in_bit};
  assign w_r3_reg = {r_r3[21:0], w_r3_fb ^ w_in_bit};

  // Majority clock: only registers whose clock bit agrees with the majority shift.
  assign w_c1  = r_r1[8];
  assign w_c2  = r_r2[10];
  assign w_c3  = r_r3[10];
  assign w_maj = (w_c1 & w_c2) | (w_c1 & w_c3) | (w_c2 & w_c3);

  assign w_r1_maj = (w_c1 == w_maj) ? {r_r1[17:0], w_r1_fb} : r_r1;
  assign w_r2_maj = (w_c2 == w_maj) ? {r_r2[20:0], w_r2_fb} : r_r2;
  assign w_r3_maj = (w_c3 == w_maj) ? {r_r3[21:0], w_r3_fb} : r_r3;

  assign w_handshake = r_ks_valid & ks_ready;
  assign w_last_bit  = (r_cnt == CNT_W'(KS_BITS - 1));

  // Control FSM, LFSR state and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_r1       <= '0;
      r_r2       <= '0;
      r_r3       <= '0;
      r_ks_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the register values from before this edge.
      r_done <= 1'b0;
      // busy trails the state by one edge, which keeps it high through the
      // cycle in which done pulses.
      r_busy <= (r_state != S_IDLE);

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_r1    <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_cnt   <= '0;
            r_state <= S_LOAD_KEY;
          end
        end

        S_LOAD_KEY: begin
          r_r1 <= w_r1_reg;
          r_r2 <= w_r2_reg;
          r_r3 <= w_r3_reg;
          if (r_cnt == CNT_W'(KEY_BITS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_FRAME;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_LOAD_FRAME: begin
          r_r1 <= w_r1_reg;
          r_r2 <= w_r2_reg;
          r_r3 <= w_r3_reg;
          if (r_cnt == CNT_W'(FRAME_BITS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_MIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // The final mixing clock is the pre-output clock of the first bit.
        S_MIX: begin
          r_r1 <= w_r1_maj;
          r_r2 <= w_r2_maj;
          r_r3 <= w_r3_maj;
          if (r_cnt == CNT_W'(MIX_CYCLES)) begin
            r_cnt      <= '0;
            r_ks_valid <= 1'b1;
            r_state    <= S_STREAM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // Advance only on an accepted bit; the last bit leaves the registers
        // untouched so the debug outputs show the state that produced it.
        S_STREAM: begin
          if (w_handshake) begin
            if (w_last_bit) begin
              r_cnt      <= '0;
              r_ks_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_r1  <= w_r1_maj;
              r_r2  <= w_r2_maj;
              r_r3  <= w_r3_maj;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          r_cnt      <= '0;
          r_ks_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign ks_bit   = r_r1[18] ^ r_r2[21] ^ r_r3[22];
  assign ks_valid = r_ks_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign out19    = r_r1;
  assign out22    = r_r2;
  assign out23    = r_r3;

endmodule

// File: tb/tb_a51_keystream_gen.sv
// Self-checking bench for a51_keystream_gen: a vote-counting A5/1 reference
// model predicts the 228-bit stream, a monitor checks every accepted bit and
// stall stability, and published vectors pin the model.
module tb_a51_keystream_gen;

  localparam int KS = 228;
  localparam logic [63:0] KNOWN_KEY   = 64'hEFCDAB8967452312;
  localparam logic [21:0] KNOWN_FRAME = 22'h000134;

  logic        clock;
  logic        reset;
  logic [63:0] key;
  logic [21:0] frame;
  logic        start;
  logic        ks_ready;
  logic        ks_valid;
  logic        ks_bit;
  logic        busy;
  logic        done;
  logic [18:0] out19;
  logic [21:0] out22;
  logic [22:0] out23;

  a51_keystream_gen dut (
    .clock    (clock),
    .reset    (reset),
    .key      (key),
    .frame    (frame),
    .start    (start),
    .ks_ready (ks_ready),
    .ks_valid (ks_valid),
    .ks_bit   (ks_bit),
    .busy     (busy),
    .done     (done),
    .out19    (out19),
    .out22    (out22),
    .out23    (out23)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit [KS-1:0] exp_vec;
  bit [KS-1:0] got_vec;
  bit [KS-1:0] lit_stream;
  int          hs_count;
  int          last_hs_cyc;
  bit          mon_en;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input bit [KS-1:0] act, input bit [KS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Register idx: 0=19-bit, 1=22-bit, 2=23-bit. Taps as bit masks.
  function automatic bit [22:0] lfsr_shift(input bit [22:0] r, input int idx, input bit in_bit);
    bit [22:0] tap;
    bit [22:0] mask;
    case (idx)
      0:       begin tap = 23'h072000; mask = 23'h07FFFF; end
      1:       begin tap = 23'h300000; mask = 23'h3FFFFF; end
      default: begin tap = 23'h700080; mask = 23'h7FFFFF; end
    endcase
    return ((r << 1) | {22'd0, (^(r & tap)) ^ in_bit}) & mask;
  endfunction

  function automatic void maj_step(inout bit [22:0] a, inout bit [22:0] b, inout bit [22:0] c);
    int  votes;
    bit  m;
    votes = int'(a[8]) + int'(b[10]) + int'(c[10]);
    m = (votes >= 2);
    if (a[8]  == m) a = lfsr_shift(a, 0, 1'b0);
    if (b[10] == m) b = lfsr_shift(b, 1, 1'b0);
    if (c[10] == m) c = lfsr_shift(c, 2, 1'b0);
  endfunction

  function automatic bit [KS-1:0] model_stream(input bit [63:0] k, input bit [21:0] f);
    bit [22:0]   a;
    bit [22:0]   b;
    bit [22:0]   c;
    bit          in_bit;
    bit [KS-1:0] s;
    a = '0; b = '0; c = '0; s = '0;
    for (int i = 0; i < 86; i++) begin
      in_bit = (i < 64) ? k[i] : f[i-64];
      a = lfsr_shift(a, 0, in_bit);
      b = lfsr_shift(b, 1, in_bit);
      c = lfsr_shift(c, 2, in_bit);
    end
    for (int i = 0; i < 101; i++) maj_step(a, b, c);
    for (int i = 0; i < KS; i++) begin
      s[i] = a[18] ^ b[21] ^ c[22];
      if (i < KS - 1) maj_step(a, b, c);
    end
    return s;
  endfunction

  // ---------------- compare process ----------------
  bit          prev_stall;
  logic [64:0] prev_snap;

  always @(negedge clock) begin
    if (reset && mon_en) begin
      if (prev_stall)
        check($sformatf("stall hold @bit %0d", hs_count),
              {ks_bit, out19, out22, out23}, prev_snap[64:0]);
      if (ks_valid && ks_ready) begin
        if (hs_count < KS) begin
          check($sformatf("ks_bit[%0d]", hs_count), ks_bit, exp_vec[hs_count]);
          got_vec[hs_count] = ks_bit;
        end else begin
          check("extra handshake", hs_count, KS - 1);
        end
        hs_count++;
        last_hs_cyc = cyc;
      end
      prev_stall = ks_valid && !ks_ready;
      prev_snap  = {ks_bit, out19, out22, out23};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_stream(input string tag, input bit [63:0] k, input bit [21:0] f,
                            input bit rand_ready, input bit poke_start,
                            input bit has_lit, input bit [KS-1:0] lit);
    int t_valid;
    int done_cyc;
    bit finished;
    bit any_nz;
    t_valid = -1; done_cyc = -1; finished = 0; any_nz = 0;
    key = k; frame = f;
    exp_vec = model_stream(k, f);
    hs_count = 0; got_vec = '0; last_hs_cyc = -1;
    mon_en = 1'b1;
    ks_ready = 1'b0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;   // accept edge = cycle 0
    for (int c = 1; c <= 3000 && !finished; c++) begin
      @(posedge clock); #1;
      start = poke_start && (c == 70 || c == 300);
      if (rand_ready)
        ks_ready = ((c % 97) >= 60 && (c % 97) < 80) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        ks_ready = 1'b1;
      @(negedge clock); #1;
      any_nz |= |{out19, out22, out23};
      if (c == 1) check({tag, " busy at cycle 1"}, busy, 1);
      if (ks_valid && t_valid < 0) begin
        t_valid = c;
        check({tag, " ks_valid rise cycle"}, t_valid, 187);
      end
      if (done_cyc >= 0) begin
        check({tag, " busy after done"}, busy, 0);
        check({tag, " done single pulse"}, done, 0);
        finished = 1;
      end else if (done) begin
        done_cyc = cyc;
        check({tag, " busy in done cycle"}, busy, 1);
        check({tag, " done after last handshake"}, done_cyc, last_hs_cyc + 1);
        check({tag, " handshakes at done"}, hs_count, KS);
      end
    end
    start = 1'b0;
    if (!finished) check({tag, " timeout waiting for done"}, 0, 1);
    if (has_lit) check_wide({tag, " stream vs vector"}, got_vec, lit);
    if (k == 0 && f == 0) check({tag, " registers stayed zero"}, any_nz, 0);
    mon_en = 1'b0;
    ks_ready = 1'b0;
  endtask

  task automatic reset_mid_stream();
    key = KNOWN_KEY; frame = KNOWN_FRAME;
    exp_vec = model_stream(KNOWN_KEY, KNOWN_FRAME);
    hs_count = 0; got_vec = '0;
    mon_en = 1'b1;
    @(posedge clock); #1 start = 1'b1; ks_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int c = 0; c < 1000 && hs_count < 50; c++) @(posedge clock);
    check("reset test reached 50 bits", hs_count >= 50, 1);
    #1 mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("async reset ks_valid", ks_valid, 0);
    check("async reset busy", busy, 0);
    check("async reset regs", {out19, out22, out23}, 0);
    @(posedge clock); #1;
    check("reset edge ks_valid/busy/done", {ks_valid, busy, done, ks_bit}, 0);
    reset = 1'b1;
    ks_ready = 1'b0;
  endtask

  initial begin
    bit [119:0] lit_a;
    bit [119:0] lit_b;
    bit [KS-1:0] m;
    reset = 1'b0; start = 1'b0; ks_ready = 1'b0; key = '0; frame = '0;
    mon_en = 1'b0; prev_stall = 1'b0; prev_snap = '0; hs_count = 0; last_hs_cyc = -1;

    // Published A5/1 test vector, 114 bits per burst, MSB first.
    lit_a = 120'h534EAA582FE8151AB6E1855A728C00;
    lit_b = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    for (int j = 0; j < 114; j++) begin
      lit_stream[j]       = lit_a[119-j];
      lit_stream[114 + j] = lit_b[119-j];
    end

    repeat (3) @(posedge clock);
    #1;
    check("reset ks_valid", ks_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ks_bit", ks_bit, 0);
    check("reset regs", {out19, out22, out23}, 0);
    reset = 1'b1;

    m = model_stream(KNOWN_KEY, KNOWN_FRAME);
    check_wide("model vs published vector", m, lit_stream);
    m = model_stream(64'd0, 22'd0);
    check_wide("model zero key", m, '0);

    run_stream("known",         KNOWN_KEY, KNOWN_FRAME, 1'b0, 1'b0, 1'b1, lit_stream);
    run_stream("backpressure",  KNOWN_KEY, KNOWN_FRAME, 1'b1, 1'b0, 1'b1, lit_stream);
    run_stream("zero",          64'd0,     22'd0,       1'b0, 1'b0, 1'b1, '0);
    run_stream("start_ignored", KNOWN_KEY, KNOWN_FRAME, 1'b0, 1'b1, 1'b1, lit_stream);
    run_stream("rerun",         KNOWN_KEY, KNOWN_FRAME, 1'b0, 1'b0, 1'b1, lit_stream);
    reset_mid_stream();
    run_stream("after_reset",   KNOWN_KEY, KNOWN_FRAME, 1'b1, 1'b0, 1'b1, lit_stream);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/a51_keystream_gen.md
Name: a51_keystream_gen

Overview:
- A5/1 keystream core: three majority-clocked LFSRs (19, 22, 23 bits).
- Loads a 64-bit session key and a 22-bit frame number, then runs the mixing phase.
- Streams KS_BITS keystream bits one at a time over a valid/ready handshake.
- Sits between the key/frame capture logic (PS/2 entry path) and the XOR encrypt/decrypt plus LCD display stage of the a51 top level.

Parameters:
KEY_BITS, 64, session key length; bits absorbed in LOAD_KEY
FRAME_BITS, 22, frame number length; bits absorbed in LOAD_FRAME
MIX_CYCLES, 100, discarded majority clocks before the first output bit
KS_BITS, 228, keystream bits produced per start (two 114-bit bursts)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
key  in  KEY_BITS  session key; key[0] absorbed first; sampled every LOAD_KEY cycle, so hold it stable while busy
frame  in  FRAME_BITS  frame number; frame[0] absorbed first; hold stable while busy
start  in  1  one-cycle request; accepted only in IDLE
ks_ready  in  1  downstream ready to take ks_bit
ks_valid  out  1  ks_bit is valid
ks_bit  out  1  keystream bit, R1[18]^R2[21]^R3[22]
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last bit is accepted
out19  out  19  R1 contents (debug)
out22  out  22  R2 contents (debug)
out23  out  23  R3 contents (debug)

Behaviour:
- Reset (reset=0, async): state IDLE, R1/R2/R3=0, counter=0, ks_valid=0, ks_bit=0, busy=0, done=0.
- Feedback taps:
  - R1: fb = R1[13]^R1[16]^R1[17]^R1[18].
  - R2: fb = R2[20]^R2[21].
  - R3: fb = R3[7]^R3[20]^R3[21]^R3[22].
  - Shift is toward MSB; new bit enters at [0].
- Regular clock: all three registers shift, and each bit 0 gets fb^in.
- Majority clock:
  - Clock bits are R1[8], R2[10], R3[10]; m = majority of the three.
  - Only registers whose clock bit equals m shift, with in=0.
- States:
  - IDLE: start=1 clears R1-R3 and the counter, then goes to LOAD_KEY. start is ignored in every other state.
  - LOAD_KEY: KEY_BITS cycles. Cycle i regular-clocks with in=key[i]. Then LOAD_FRAME.
  - LOAD_FRAME: FRAME_BITS cycles. Cycle i regular-clocks with in=frame[i]. Then MIX.
  - MIX: MIX_CYCLES+1 majority clocks. The extra clock is the pre-output clock of the first bit. Then STREAM with ks_valid=1.
  - STREAM: ks_bit is combinational from the current MSBs.
    - Each cycle with ks_valid&ks_ready counts one bit. If it is not the last, all registers majority-clock once.
    - Without the handshake, registers and ks_bit are held.
    - On the KS_BITS-th handshake: no register clock, ks_valid drops next cycle, done=1 for one cycle, state goes to IDLE.
- Latency: the start-accept edge is cycle 0. ks_valid rises at cycle KEY_BITS+FRAME_BITS+MIX_CYCLES+1 = 187 with defaults. busy is high from cycle 1 through the cycle done pulses, inclusive.
- Counter: 9 bits, wide enough for max(KEY_BITS, MIX_CYCLES+1, KS_BITS); reset to 0 on each state entry.
- ks_valid depends only on state, never on ks_ready.
- R1-R3 persist after done until the next start, so out19/out22/out23 stay readable.
- All-zero registers remain zero; this is not treated as an error.

Test Plan:
- Reset: assert reset=0 mid-STREAM (after 50 bits) -> next edge shows ks_valid=0, busy=0, out19/22/23=0; reset=1 then start -> full 187-cycle sequence restarts.
- Known vector: key=64'hEFCDAB8967452312, frame=22'h000134, ks_ready=1 -> first 114 bits MSB-first = 534EAA582FE8151AB6E1855A728C00 (last 6 bits of the final nibble group padding ignored), next 114 = 24FD35A35D5FB6526D32F906DF1AC0; done pulses exactly once.
- Timing: start at cycle 0 -> ks_valid first high at cycle 187, busy high at cycle 1, done high in the cycle after the 228th handshake, then busy=0.
- Backpressure: same vector with ks_ready toggling pseudo-randomly (including 20-cycle low stretches) -> identical 228-bit sequence; ks_bit and out19/22/23 are stable whenever ks_ready=0.
- Zero key/frame: key=0, frame=0 -> R1-R3 stay 0 throughout; 228 bits all 0.
- start ignored while busy: pulse start during LOAD_FRAME and during STREAM -> no restart, output identical to the known vector; start in IDLE after done -> second run reproduces the same stream.
